// File: rtl/scan_sel_sequencer_pkg.sv
// Shared types and constants for the scan select sequencer: mode codes,
// FSM state encoding and the code range of the 4-bit select.
package scan_sel_sequencer_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_PP      = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    localparam logic [3:0] SEL_MAX = 4'hF;
    localparam logic [3:0] SEL_MIN = 4'h0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One step of the 4-bit code; natural 4-bit overflow gives the 15->0 / 0->15 wrap.
    function automatic logic [3:0] sel_step(input logic [3:0] sel, input logic down);
        return down ? (sel - 4'd1) : (sel + 4'd1);
    endfunction

endpackage

// File: rtl/scan_sel_sequencer_if.sv
// Control/status bundle between a scan controller (master) and the
// sequencer (slave) that drives the decoder select lines.
interface scan_sel_sequencer_if #(
    parameter int DIV_W = 8
);
    logic             en;
    logic             dir;
    logic [1:0]       mode;
    logic [DIV_W-1:0] div;
    logic             load;
    logic [3:0]       load_val;
    logic [3:0]       sel;
    logic             tick;
    logic             done;
    logic             busy;

    modport master (
        output en, dir, mode, div, load, load_val,
        input  sel, tick, done, busy
    );

    modport slave (
        input  en, dir, mode, div, load, load_val,
        output sel, tick, done, busy
    );
endinterface

// File: rtl/tick_prescaler.sv
// Rate divider: counts 0..div while enabled and flags a step on the cycle
// the count reaches (or passes) div.
module tick_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             step
);

    logic [DIV_W-1:0] cnt;

    // >= rather than == so a div lowered below the current count fires at once.
    assign step = en && !clr && (cnt >= div);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst || clr || !en) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/scan_sel_sequencer.sv
// Clocked, loadable 4-bit select source for a 4:16 decoder: steps the code at
// a programmable rate in wrap, ping-pong or one-shot mode.
module scan_sel_sequencer
    import scan_sel_sequencer_pkg::*;
#(
    parameter int         DIV_W    = 8,
    parameter logic [3:0] SEL_INIT = 4'h0
) (
    input logic                 clk,
    input logic                 rst,
    scan_sel_sequencer_if.slave bus
);

    state_t     state, state_nxt;
    logic [3:0] sel_q, sel_nxt;
    logic       pp_up, pp_up_nxt;
    logic       tick_q, tick_nxt;
    logic       done_q, done_nxt;
    logic       busy_q;
    logic       run_en;
    logic       step;
    logic [3:0] sel_term;

    assign run_en   = (state == ST_RUN) && bus.en;
    assign sel_term = bus.dir ? SEL_MIN : SEL_MAX;

    tick_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (bus.load),
        .en   (run_en),
        .div  (bus.div),
        .step (step)
    );

    // NOTE: every signal assigned here gets a default first, so no path through
    // the case/if tree can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel_q;
        pp_up_nxt = pp_up;
        tick_nxt  = 1'b0;
        done_nxt  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.en) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!bus.en) begin
                    state_nxt = ST_IDLE;
                end else if (step) begin
                    case (bus.mode)
                        MODE_PP: begin
                            tick_nxt = 1'b1;
                            // Reverse at the endpoint itself so 15 and 0 are never repeated.
                            if (pp_up && sel_q == SEL_MAX) begin
                                pp_up_nxt = 1'b0;
                                sel_nxt   = sel_q - 4'd1;
                            end else if (!pp_up && sel_q == SEL_MIN) begin
                                pp_up_nxt = 1'b1;
                                sel_nxt   = sel_q + 4'd1;
                            end else begin
                                sel_nxt = sel_step(sel_q, !pp_up);
                            end
                        end
                        MODE_ONESHOT: begin
                            if (sel_q == sel_term) begin
                                done_nxt  = 1'b1;
                                state_nxt = ST_DONE;
                            end else begin
                                tick_nxt = 1'b1;
                                sel_nxt  = sel_step(sel_q, bus.dir);
                                if (sel_nxt == sel_term) begin
                                    done_nxt  = 1'b1;
                                    state_nxt = ST_DONE;
                                end
                            end
                        end
                        default: begin
                            tick_nxt = 1'b1;
                            sel_nxt  = sel_step(sel_q, bus.dir);
                        end
                    endcase
                end
            end
            ST_DONE: begin
                if (!bus.en || bus.load) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Load overrides any step decided above in the same cycle.
        if (bus.load) begin
            sel_nxt   = bus.load_val;
            pp_up_nxt = 1'b1;
            tick_nxt  = 1'b0;
            done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            sel_q  <= SEL_INIT;
            pp_up  <= 1'b1;
            tick_q <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            sel_q  <= sel_nxt;
            pp_up  <= pp_up_nxt;
            tick_q <= tick_nxt;
            done_q <= done_nxt;
            busy_q <= (state_nxt == ST_RUN);
        end
    end

    assign bus.sel  = sel_q;
    assign bus.tick = tick_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_scan_sel_sequencer.sv
// Directed bench for scan_sel_sequencer: wrap, ping-pong, one-shot, load
// priority, enable gaps and reset, with hand-computed expectations.
module tb_scan_sel_sequencer;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    scan_sel_sequencer_if #(.DIV_W(8)) sif ();

    scan_sel_sequencer #(.DIV_W(8), .SEL_INIT(4'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] s, input logic t,
                              input logic d, input logic b);
        check({tag, ".sel"},  {12'd0, sif.sel},  {12'd0, s});
        check({tag, ".tick"}, {15'd0, sif.tick}, {15'd0, t});
        check({tag, ".done"}, {15'd0, sif.done}, {15'd0, d});
        check({tag, ".busy"}, {15'd0, sif.busy}, {15'd0, b});
    endtask

    initial begin
        logic [3:0]  exp_sel;
        logic [15:0] onehot;
        tests = 0;
        fails = 0;

        rst          = 1'b1;
        sif.en       = 1'b0;
        sif.dir      = 1'b0;
        sif.mode     = 2'b00;
        sif.div      = 8'd3;
        sif.load     = 1'b0;
        sif.load_val = 4'h0;
        cyc(2);
        check_outs("reset", 4'h0, 1'b0, 1'b0, 1'b0);

        // Wrap up, div=3: tick every 4 cycles, first one 4 cycles after enable.
        rst    = 1'b0;
        sif.en = 1'b1;
        cyc(1);
        check_outs("wrap.entry", 4'h0, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            cyc(3);
            check("wrap.gap.tick", {15'd0, sif.tick}, 16'd0);
            cyc(1);
            exp_sel = 4'(k);
            check("wrap.step.sel",  {12'd0, sif.sel}, {12'd0, exp_sel});
            check("wrap.step.tick", {15'd0, sif.tick}, 16'd1);
        end
        sif.en = 1'b0;
        cyc(1);
        check_outs("wrap.stop", 4'h0, 1'b0, 1'b0, 1'b0);

        // Ping-pong, div=0: 1..15,14..0,1 on consecutive cycles.
        sif.mode = 2'b01;
        sif.div  = 8'd0;
        sif.en   = 1'b1;
        cyc(1);
        check_outs("pp.entry", 4'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 31; i++) begin
            cyc(1);
            if (i <= 15)      exp_sel = 4'(i);
            else if (i <= 30) exp_sel = 4'(30 - i);
            else              exp_sel = 4'(i - 30);
            check("pp.sel",  {12'd0, sif.sel}, {12'd0, exp_sel});
            check("pp.tick", {15'd0, sif.tick}, 16'd1);
        end
        sif.en = 1'b0;
        cyc(1);
        check_outs("pp.stop", 4'h1, 1'b0, 1'b0, 1'b0);

        // One-shot down from 3: 2,1,0 with done on 0, then hold.
        sif.mode     = 2'b10;
        sif.dir      = 1'b1;
        sif.load     = 1'b1;
        sif.load_val = 4'h3;
        cyc(1);
        check_outs("os.load", 4'h3, 1'b0, 1'b0, 1'b0);
        sif.load = 1'b0;
        sif.en   = 1'b1;
        cyc(1);
        check_outs("os.entry", 4'h3, 1'b0, 1'b0, 1'b1);
        cyc(1);
        check_outs("os.s2", 4'h2, 1'b1, 1'b0, 1'b1);
        cyc(1);
        check_outs("os.s1", 4'h1, 1'b1, 1'b0, 1'b1);
        cyc(1);
        check_outs("os.s0", 4'h0, 1'b1, 1'b1, 1'b0);
        cyc(1);
        check_outs("os.after", 4'h0, 1'b0, 1'b0, 1'b0);
        cyc(2);
        check_outs("os.hold", 4'h0, 1'b0, 1'b0, 1'b0);

        // Load from DONE at the terminal code: back through IDLE to RUN, done without tick.
        sif.load     = 1'b1;
        sif.load_val = 4'h0;
        cyc(1);
        check_outs("os.reload", 4'h0, 1'b0, 1'b0, 1'b0);
        sif.load = 1'b0;
        cyc(1);
        check_outs("os.rerun", 4'h0, 1'b0, 1'b0, 1'b1);
        cyc(1);
        check_outs("os.term", 4'h0, 1'b0, 1'b1, 1'b0);
        sif.en = 1'b0;
        cyc(1);

        // Load coincident with a due step wins; next step a full period later.
        sif.mode = 2'b00;
        sif.dir  = 1'b0;
        sif.div  = 8'd3;
        sif.en   = 1'b1;
        cyc(1);
        check_outs("ld.entry", 4'h0, 1'b0, 1'b0, 1'b1);
        cyc(4);
        check_outs("ld.first", 4'h1, 1'b1, 1'b0, 1'b1);
        cyc(3);
        sif.load     = 1'b1;
        sif.load_val = 4'h9;
        cyc(1);
        check_outs("ld.collide", 4'h9, 1'b0, 1'b0, 1'b1);
        sif.load = 1'b0;
        cyc(3);
        check_outs("ld.gap", 4'h9, 1'b0, 1'b0, 1'b1);
        cyc(1);
        check_outs("ld.next", 4'hA, 1'b1, 1'b0, 1'b1);

        // Enable gap at cnt=2 of div=5; full period after re-enable.
        sif.div = 8'd5;
        cyc(2);
        sif.en = 1'b0;
        cyc(1);
        check_outs("gap.low", 4'hA, 1'b0, 1'b0, 1'b0);
        cyc(2);
        sif.en = 1'b1;
        cyc(1);
        check_outs("gap.reen", 4'hA, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            check("gap.wait.tick", {15'd0, sif.tick}, 16'd0);
        end
        cyc(1);
        check_outs("gap.step", 4'hB, 1'b1, 1'b0, 1'b1);

        // Reset while running at sel=7.
        sif.load     = 1'b1;
        sif.load_val = 4'h7;
        cyc(1);
        check_outs("rst.pre", 4'h7, 1'b0, 1'b0, 1'b1);
        sif.load = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(1);
        check_outs("rst.mid", 4'h0, 1'b0, 1'b0, 1'b0);
        onehot = 16'd1 << sif.sel;
        check("rst.decode", onehot, 16'h0001);
        rst    = 1'b0;
        sif.en = 1'b0;
        cyc(1);
        check_outs("rst.idle", 4'h0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
